ram_sdp_clr: RTL and testbench

- Parametrised single-clock simple-dual-port RAM: one write port, one read port.
- Per-byte write enables.
- Write-first forwarding on same-address read/write collisions.
- Built-in clear engine that zeroes the whole array after reset or on request.
- Sits between datapath producers and consumers as a general scratch/line buffer; supersedes the two-clock pseudo-dual-port RAM where one clock domain suffices.

---
 rtl/ram_sdp_clr.sv | 120 ++++++++++++
 tb/tb_ram_sdp_clr.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: single-clock simple-dual-port RAM with byte enables, write-first forwarding and a clear engine
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset; restarts the clear engine at address 0
//   clr      : request a full-array clear, sampled only when not busy
//   busy     : high while the clear engine runs; write/read ports are ignored
//   wr_en    : write strobe; wr_be byte enables; wr_addr / wr_data write address and data
//   rd_en    : read strobe; rd_addr read address
//   rd_data  : read data, held until the next accepted read
//   rd_valid : one-cycle pulse marking new rd_data
//   Optional macro RAM_SDP_OUTREG_EN adds an output register stage (2-cycle read latency).
module ram_sdp_clr #(
    parameter int DW = 16,
    parameter int AW = 6,
    parameter int MD = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [DW/8-1:0]     wr_be,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic                rd_valid
);
    localparam int BE_W = DW / 8;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_mem [MD];
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          w_busy;
    logic          w_last;
    logic          w_wr_in;
    logic          w_rd_in;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_hit;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_fwd;

    assign w_busy  = (r_state == S_CLEAR);
    assign w_last  = (r_cnt == AW'(MD - 1));
    assign w_wr_in = int'(wr_addr) < MD;
    assign w_rd_in = int'(rd_addr) < MD;
    assign w_wr_ok = !w_busy && wr_en && w_wr_in;
    assign w_rd_ok = !w_busy && rd_en;
    assign w_hit   = w_wr_ok && (wr_addr == rd_addr);
    assign w_old   = w_rd_in ? r_mem[rd_addr] : '0;
    assign busy    = w_busy;

    // Write-first: a byte being written this edge overrides the stored byte on a same-address read.
    genvar g;
    generate
        for (g = 0; g < BE_W; g++) begin : g_fwd
            assign w_fwd[8*g +: 8] = (w_hit && wr_be[g]) ? wr_data[8*g +: 8] : w_old[8*g +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_state <= w_last ? S_READY : S_CLEAR;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end else if (clr) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end
    end

    // Array has no reset so it maps onto block RAM; the clear engine owns the port while busy.
    always_ff @(posedge clk) begin
        if (w_busy)
            r_mem[r_cnt] <= '0;
        else if (w_wr_ok)
            for (int i = 0; i < BE_W; i++)
                if (wr_be[i]) r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) r_rd_data <= w_rd_in ? w_fwd : '0;
        end
    end

`ifdef RAM_SDP_OUTREG_EN
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_busy) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) r_out_data <= r_rd_data;
        end
    end

    assign rd_data  = r_out_data;
    assign rd_valid = r_out_valid;
`else
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif
endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb_ram_sdp_clr: scoreboard bench driving a full-depth (MD=64) and a partial-depth (MD=40) RAM in parallel
module tb_ram_sdp_clr;
`ifdef RAM_SDP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  wr_be = '0;
    logic [5:0]  wr_addr = '0;
    logic [5:0]  rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic        busy_a, busy_b, vld_a, vld_b;
    logic [15:0] dat_a, dat_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          na, nb;
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] m_a[64];
    logic [15:0] m_b[40];

    ram_sdp_clr #(.DW(16), .AW(6), .MD(64)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat_a), .rd_valid(vld_a)
    );

    ram_sdp_clr #(.DW(16), .AW(6), .MD(40)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat_b), .rd_valid(vld_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", n, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (vld_a) begin
            if (q_a.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                chk("a_data", 32'(dat_a), 32'(e.d));
                chk("a_latency", cyc, e.due);
            end
        end else if (q_a.size() > 0 && q_a[0].due < cyc) begin
            chk("a_missing_valid", 32'd0, 32'd1);
            void'(q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (vld_b) begin
            if (q_b.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                chk("b_data", 32'(dat_b), 32'(e.d));
                chk("b_latency", cyc, e.due);
            end
        end else if (q_b.size() > 0 && q_b[0].due < cyc) begin
            chk("b_missing_valid", 32'd0, 32'd1);
            void'(q_b.pop_front());
        end
    end

    // One cycle of traffic on both DUTs; expectations come from the bench's own array models.
    task automatic op(input bit we, input logic [5:0] wa, input logic [15:0] wd, input logic [1:0] be,
                      input bit re, input logic [5:0] ra);
        exp_t ea, eb;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re) begin
            ea.due = cyc + LAT;
            ea.d   = (we && wa == ra) ? merge(m_a[ra], wd, be) : m_a[ra];
            eb.due = cyc + LAT;
            eb.d   = (ra >= 6'd40) ? 16'h0000 : (we && wa == ra) ? merge(m_b[ra], wd, be) : m_b[ra];
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
        if (we) begin
            m_a[wa] = merge(m_a[wa], wd, be);
            if (wa < 6'd40) m_b[wa] = merge(m_b[wa], wd, be);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic zero_models();
        foreach (m_a[i]) m_a[i] = '0;
        foreach (m_b[i]) m_b[i] = '0;
    endtask

    // Counts sampled busy cycles from now; optionally pokes a write/read while busy.
    task automatic count_busy(input bit poke, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int n = 0; n < 200 && (busy_a || busy_b); n++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (poke && n == 5) begin
                wr_en = 1'b1; wr_be = 2'b11; wr_addr = 6'd3; wr_data = 16'h1111;
                rd_en = 1'b1; rd_addr = 6'd3;
            end else begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        zero_models();
        repeat (3) @(negedge clk);
        chk("reset_busy_a", 32'(busy_a), 32'd1);
        chk("reset_busy_b", 32'(busy_b), 32'd1);
        chk("reset_valid_a", 32'(vld_a), 32'd0);
        chk("reset_data_a", 32'(dat_a), 32'd0);
        chk("reset_data_b", 32'(dat_b), 32'd0);
        rst = 1'b0;
        count_busy(1'b0, na, nb);
        chk("clear_after_reset_cycles_a", na, 64);
        chk("clear_after_reset_cycles_b", nb, 40);

        for (int a = 0; a < 64; a++) op(1'b0, '0, '0, '0, 1'b1, 6'(a));

        op(1'b1, 6'd5, 16'hABCD, 2'b11, 1'b0, '0);
        op(1'b1, 6'd5, 16'h1234, 2'b01, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd5);
        op(1'b1, 6'd5, 16'hFFFF, 2'b00, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd5);

        op(1'b1, 6'd9, 16'h5555, 2'b11, 1'b0, '0);
        op(1'b1, 6'd9, 16'hAAAA, 2'b10, 1'b1, 6'd9);
        op(1'b0, '0, '0, '0, 1'b1, 6'd9);
        op(1'b1, 6'd10, 16'h1357, 2'b11, 1'b1, 6'd5);
        op(1'b1, 6'd11, 16'h2468, 2'b01, 1'b1, 6'd11);
        op(1'b0, '0, '0, '0, 1'b1, 6'd10);

        op(1'b1, 6'd50, 16'hFFFF, 2'b11, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd50);
        op(1'b0, '0, '0, '0, 1'b1, 6'd39);
        op(1'b1, 6'd45, 16'hBEEF, 2'b11, 1'b1, 6'd45);

        for (int a = 0; a < 64; a++) op(1'b1, 6'(a), 16'(a * 257 + 1), 2'b11, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd5);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        count_busy(1'b1, na, nb);
        chk("clear_request_cycles_a", na, 64);
        chk("clear_request_cycles_b", nb, 40);
        chk("hold_after_clear_a", 32'(dat_a), 32'h0506);
        chk("hold_after_clear_b", 32'(dat_b), 32'h0506);
        zero_models();
        for (int a = 0; a < 64; a++) op(1'b0, '0, '0, '0, 1'b1, 6'(a));

        op(1'b1, 6'd7, 16'h7777, 2'b11, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_clears_data_a", 32'(dat_a), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_busy(1'b0, na, nb);
        chk("reset_mid_clear_cycles_a", na, 64);
        chk("reset_mid_clear_cycles_b", nb, 40);
        zero_models();
        op(1'b0, '0, '0, '0, 1'b1, 6'd7);
        op(1'b0, '0, '0, '0, 1'b1, 6'd9);

        repeat (4) @(negedge clk);
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
